// File: rtl/demux_lanes.sv
// demux_lanes: splits an interleaved word stream into two lanes (lane 0 first), each behind a DEPTH-entry FIFO.
// Optional per-lane pop counters cnt_0/cnt_1 when DEMUX_LANES_CNT_EN is defined.
module demux_lanes #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic [WIDTH-1:0] data_1,
    output logic             valid_1,
    input  logic             ready_1
`ifdef DEMUX_LANES_CNT_EN
    ,
    output logic [7:0]       cnt_0,
    output logic [7:0]       cnt_1
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic             sel_q, sel_d;
    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [WIDTH-1:0] mem_d [2][DEPTH];
    logic [AW-1:0]    wr_q [2], wr_d [2], rd_q [2], rd_d [2];
    logic [CW-1:0]    count_q [2], count_d [2];
    logic [1:0]       full, empty, push, pop, rdy;

    always_comb begin
        rdy = {ready_1, ready_0};
        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            full[i]  = count_q[i] == CW'(DEPTH);
            empty[i] = count_q[i] == '0;
        end
        // No look-ahead: a full target lane refuses input even if it pops this cycle.
        ready_in = reset_L && !full[sel_q];
        sel_d = sel_q ^ (valid_in && ready_in);
        for (int i = 0; i < 2; i++) begin
            push[i]     = valid_in && ready_in && (sel_q == 1'(i));
            pop[i]      = !empty[i] && rdy[i];
            wr_d[i]     = wr_q[i] + AW'(push[i]);
            rd_d[i]     = rd_q[i] + AW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            if (push[i]) mem_d[i][wr_q[i]] = data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_q[i]    <= '0;
                rd_q[i]    <= '0;
                count_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign valid_0 = !empty[0];
    assign valid_1 = !empty[1];
    assign data_0  = valid_0 ? mem_q[0][rd_q[0]] : '0;
    assign data_1  = valid_1 ? mem_q[1][rd_q[1]] : '0;

`ifdef DEMUX_LANES_CNT_EN
    logic [7:0] pcnt_q [2], pcnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) pcnt_d[i] = pcnt_q[i] + 8'(pop[i]);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pcnt_q[0] <= '0;
            pcnt_q[1] <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign cnt_0 = pcnt_q[0];
    assign cnt_1 = pcnt_q[1];
`endif
endmodule

// File: tb/tb_demux_lanes.sv
// tb_demux_lanes: scoreboard bench; lane queues model the FIFOs, a negedge monitor checks every output.
module tb_demux_lanes;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 0;
    logic             reset_L = 0;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid_in = 0;
    logic             ready_in;
    logic [WIDTH-1:0] data_0, data_1;
    logic             valid_0, valid_1;
    logic             ready_0 = 0, ready_1 = 0;
`ifdef DEMUX_LANES_CNT_EN
    logic [7:0]       cnt_0, cnt_1;
    logic [7:0]       mcnt0 = 0, mcnt1 = 0;
`endif

    int checks = 0;
    int fails = 0;
    logic [WIDTH-1:0] q0[$], q1[$];
    bit msel = 0;
    bit er, ev0, ev1;

    demux_lanes #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_L(reset_L),
        .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_0(data_0), .valid_0(valid_0), .ready_0(ready_0),
        .data_1(data_1), .valid_1(valid_1), .ready_1(ready_1)
`ifdef DEMUX_LANES_CNT_EN
        , .cnt_0(cnt_0), .cnt_1(cnt_1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs to the lane queues, then applies this cycle's handshakes to the model.
    always @(negedge clk) begin
        if (!reset_L) begin
            chk("rst_ready_in", ready_in, 0);
            chk("rst_valid_0", valid_0, 0);
            chk("rst_valid_1", valid_1, 0);
            chk("rst_data_0", data_0, 0);
            chk("rst_data_1", data_1, 0);
            q0.delete();
            q1.delete();
            msel = 0;
`ifdef DEMUX_LANES_CNT_EN
            mcnt0 = 0;
            mcnt1 = 0;
`endif
        end else begin
            er  = (msel ? q1.size() : q0.size()) < DEPTH;
            ev0 = q0.size() != 0;
            ev1 = q1.size() != 0;
            chk("ready_in", ready_in, er);
            chk("valid_0", valid_0, ev0);
            chk("valid_1", valid_1, ev1);
            chk("data_0", data_0, ev0 ? q0[0] : 0);
            chk("data_1", data_1, ev1 ? q1[0] : 0);
`ifdef DEMUX_LANES_CNT_EN
            chk("cnt_0", cnt_0, mcnt0);
            chk("cnt_1", cnt_1, mcnt1);
            if (ev0 && ready_0) mcnt0 = mcnt0 + 8'd1;
            if (ev1 && ready_1) mcnt1 = mcnt1 + 8'd1;
`endif
            if (ev0 && ready_0) void'(q0.pop_front());
            if (ev1 && ready_1) void'(q1.pop_front());
            if (valid_in && er) begin
                if (msel) q1.push_back(data_in);
                else q0.push_back(data_in);
                msel = !msel;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w);
        bit acc = 0;
        valid_in = 1;
        data_in = w;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: word %0h not accepted within 40 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held with valid_in asserted
        valid_in = 1;
        data_in = 4'h9;
        repeat (3) @(posedge clk);
        #1;
        reset_L = 1;
        valid_in = 0;
        idle(1);

        // Basic interleave
        ready_0 = 1;
        ready_1 = 1;
        for (int i = 1; i <= 4; i++) send(4'(i));
        idle(3);

        // Lane 1 stall, then release while 0xF waits
        ready_1 = 0;
        for (int i = 10; i <= 14; i++) send(4'(i));
        fork
            send(4'hF);
            begin
                repeat (4) @(posedge clk);
                #1;
                ready_1 = 1;
            end
        join
        idle(4);

        // Simultaneous push/pop on lane 0 at count 1
        ready_0 = 0;
        send(4'h3);
        send(4'h4);
        ready_0 = 1;
        send(4'h7);
        ready_0 = 0;
        idle(2);
        ready_0 = 1;
        idle(3);

        // Pointer wrap: 9 words per lane
        for (int i = 0; i < 18; i++) send(4'(i));
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 4'($urandom);
            ready_0  = 1'($urandom_range(0, 3) != 0);
            ready_1  = 1'($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        valid_in = 0;

        // Both lanes full, then reset pulse between edges
        ready_0 = 0;
        ready_1 = 0;
        idle(1);
        ready_0 = 1;
        ready_1 = 1;
        idle(6);
        ready_0 = 0;
        ready_1 = 0;
        for (int i = 1; i <= 4; i++) send(4'(i));
        valid_in = 0;
        #1;
        reset_L = 0;
        #5;
        reset_L = 1;
        @(posedge clk);
        #1;
        send(4'h5);
        valid_in = 0;
        @(negedge clk);
        chk("post_reset_lane0", data_0, 5);
        @(posedge clk);
        #1;
        send(4'h6);
        ready_0 = 1;
        ready_1 = 1;
        idle(3);

        // Final drain, bounded
        for (int k = 0; k < 50 && (q0.size() + q1.size()) != 0; k++) idle(1);
        chk("drain_empty", q0.size() + q1.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
